// File: rtl/env_follower_pkg.sv
// Shared types and constants for the env_follower envelope tracker.
// The sample rectifier lives here so any audio-side block can reuse it.
package env_follower_pkg;

   localparam int ENV_W = 8;
   localparam logic [ENV_W-1:0] MAG_MAX = 8'd254;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ON   = 2'd1,
      ST_HOLD = 2'd2
   } gate_st_e;

   // |s| limited to 127, then doubled; -128 lands on MAG_MAX as well
   function automatic logic [ENV_W-1:0] rectify(input logic [ENV_W-1:0] s);
      logic [ENV_W-1:0] a;
      a = s[ENV_W-1] ? (~s + ENV_W'(1)) : s;
      if (a[ENV_W-1]) begin
         rectify = MAG_MAX;
      end else begin
         rectify = {a[ENV_W-2:0], 1'b0};
      end
   endfunction

endpackage

// File: rtl/env_follower_if.sv
// Sample-side bus of env_follower: strobe, audio, slew/threshold controls and results.
interface env_follower_if;
   import env_follower_pkg::*;

   logic             ce;
   logic [ENV_W-1:0] sample;
   logic [ENV_W-1:0] ai;
   logic [ENV_W-1:0] ri;
   logic [ENV_W-1:0] thr_on;
   logic [ENV_W-1:0] thr_off;
   logic             peak_clr;
   logic [ENV_W-1:0] envelope;
   logic             gate;
   logic             trig;
   logic [ENV_W-1:0] peak;

   modport master (
      output ce, sample, ai, ri, thr_on, thr_off, peak_clr,
      input  envelope, gate, trig, peak
   );

   modport slave (
      input  ce, sample, ai, ri, thr_on, thr_off, peak_clr,
      output envelope, gate, trig, peak
   );

endinterface

// File: rtl/env_slew.sv
// Rectifier plus saturating attack/release slew limiter; purely combinational.
// All arithmetic is done one bit wider so env never wraps.
module env_slew
   import env_follower_pkg::*;
(
   input  logic [ENV_W-1:0] sample,
   input  logic [ENV_W-1:0] env,
   input  logic [ENV_W-1:0] ai,
   input  logic [ENV_W-1:0] ri,
   output logic [ENV_W-1:0] env_next
);

   logic [ENV_W-1:0] mag_s;
   logic [ENV_W:0]   up_s;
   logic [ENV_W:0]   dn_s;

   always_comb begin
      mag_s    = rectify(sample);
      up_s     = {1'b0, env} + {1'b0, ai};
      dn_s     = {1'b0, env} - {1'b0, ri};
      env_next = env;
      if (mag_s > env) begin
         if ((ai == {ENV_W{1'b0}}) || (up_s > {1'b0, mag_s})) begin
            env_next = mag_s;
         end else begin
            env_next = up_s[ENV_W-1:0];
         end
      end else if (mag_s < env) begin
         // dn_s[ENV_W] set means env-ri went negative
         if ((ri == {ENV_W{1'b0}}) || dn_s[ENV_W] || (dn_s[ENV_W-1:0] < mag_s)) begin
            env_next = mag_s;
         end else begin
            env_next = dn_s[ENV_W-1:0];
         end
      end else begin
         env_next = env;
      end
   end

endmodule

// File: rtl/env_follower.sv
// Envelope follower: slewed amplitude tracker with hysteretic gate, hold timer and trigger.
// Optional peak register is built only when ENV_FOLLOWER_PEAK_EN is defined.
module env_follower
   import env_follower_pkg::*;
#(
   parameter int HOLD_TICKS = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   env_follower_if.slave  bus
);

   localparam int CNT_W = (HOLD_TICKS > 2) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

   logic [ENV_W-1:0] env_q, env_d, env_next_s;
   gate_st_e         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gate_q, gate_d;
   logic             trig_q, trig_d;

   env_slew u_slew (
      .sample   (bus.sample),
      .env      (env_q),
      .ai       (bus.ai),
      .ri       (bus.ri),
      .env_next (env_next_s)
   );

   // The FSM looks at env_q, i.e. the envelope before this tick's update
   always_comb begin
      env_d   = bus.ce ? env_next_s : env_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      trig_d  = 1'b0;
      if (bus.ce) begin
         case (state_q)
            ST_IDLE: begin
               if (env_q >= bus.thr_on) begin
                  state_d = ST_ON;
                  trig_d  = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_ON: begin
               if (env_q < bus.thr_off) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_LOAD;
               end else begin
                  state_d = ST_ON;
               end
            end
            ST_HOLD: begin
               if (env_q >= bus.thr_on) begin
                  state_d = ST_ON;
               end else if ((cnt_q == {CNT_W{1'b0}}) && (env_q < bus.thr_off)) begin
                  state_d = ST_IDLE;
               end else if (cnt_q != {CNT_W{1'b0}}) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  cnt_d = cnt_q;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
            end
         endcase
      end else begin
         state_d = state_q;
      end
      gate_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         env_q   <= {ENV_W{1'b0}};
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         gate_q  <= 1'b0;
         trig_q  <= 1'b0;
      end else begin
         env_q   <= env_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gate_q  <= gate_d;
         trig_q  <= trig_d;
      end
   end

   assign bus.envelope = env_q;
   assign bus.gate     = gate_q;
   assign bus.trig     = trig_q;

`ifdef ENV_FOLLOWER_PEAK_EN
   logic [ENV_W-1:0] peak_q;

   // Clear wins over a capture in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_q <= {ENV_W{1'b0}};
      end else if (bus.peak_clr) begin
         peak_q <= {ENV_W{1'b0}};
      end else if (bus.ce && (env_next_s > peak_q)) begin
         peak_q <= env_next_s;
      end else begin
         peak_q <= peak_q;
      end
   end

   assign bus.peak = peak_q;
`else
   logic unused_peak_clr_s;
   assign unused_peak_clr_s = bus.peak_clr;
   assign bus.peak          = {ENV_W{1'b0}};
`endif

endmodule
